// File: rtl/fakeram_arb_pkg.sv
// fakeram_arb_pkg: shared constants, state enum and requester index type for the fakeram arbiter
package fakeram_arb_pkg;
  localparam int RAM_ADDR_WIDTH = 8;
  localparam int RAM_BITS = 64;
  typedef enum logic {ARB, LOCKED} state_t;
  typedef logic [$clog2(4)-1:0] req_idx_t;
endpackage

// File: rtl/fakeram_256x64_arb_rr_pick.sv
// rr_pick: combinational round-robin picker; first set req bit at or above ptr (with wrap) -> one-hot gnt and idx
module rr_pick
  import fakeram_arb_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0] req,
  input  req_idx_t     ptr,
  output logic [N-1:0] gnt,
  output req_idx_t     idx
);
  logic [2*N-1:0] req_rot;
  logic [2*N-1:0] gnt_rot;
  logic [N-1:0] pos;
  assign req_rot = {req, req} >> ptr;
  assign gnt_rot = {pos, pos} << ptr;
  assign gnt = gnt_rot[2*N-1:N];
  always_comb begin
    pos = '0;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        pos = N'(1) << i;
        idx = req_idx_t'((int'(ptr) + i) % N);
      end
    end
  end
endmodule

// File: rtl/fakeram_256x64_arb.sv
// fakeram_256x64_arb: round-robin arbiter with lock that shares one 256x64 OR-write macro among NUM_REQ requesters
// Ports: clk/rst (async active-high); req_* per-requester packed request fields and one-hot req_ready;
// rsp_valid one-cycle response pulse per requester, rsp_rd shared read data; ram_* drive the macro pins.
module fakeram_256x64_arb
  import fakeram_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_WIDTH = RAM_ADDR_WIDTH,
  parameter int BITS = RAM_BITS
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ-1:0]           req_we,
  input  logic [NUM_REQ-1:0]           req_lock,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*BITS-1:0]      req_wd,
  output logic [NUM_REQ-1:0]           rsp_valid,
  output logic [BITS-1:0]              rsp_rd,
  output logic                         ram_ce,
  output logic                         ram_we,
  output logic [ADDR_WIDTH-1:0]        ram_addr,
  output logic [BITS-1:0]              ram_wd,
  input  logic [BITS-1:0]              ram_rd
);
  state_t state, state_nxt;
  req_idx_t owner, owner_nxt, rr_ptr, ptr_nxt, pick_ptr, gi;
  logic [NUM_REQ-1:0] pick_req, gnt, grant;
  logic lock_sel;
  function automatic req_idx_t inc(input req_idx_t x);
    return req_idx_t'((int'(x) + 1) % NUM_REQ);
  endfunction
  // while locked only the owner is visible to the picker, so others never see ready
  assign pick_req = state == LOCKED ? req_valid & (NUM_REQ'(1) << owner) : req_valid;
  assign pick_ptr = state == LOCKED ? owner : rr_ptr;
  rr_pick #(.N(NUM_REQ)) u_pick (.req(pick_req), .ptr(pick_ptr), .gnt(gnt), .idx(gi));
  assign grant = rst ? '0 : gnt;
  assign req_ready = grant;
  assign ram_ce = |grant;
  assign rsp_rd = ram_rd;
  // fields are muxed by the one-hot grant so idle cycles drive clean zeros to the macro
  always_comb begin
    ram_we = 1'b0;
    ram_addr = '0;
    ram_wd = '0;
    lock_sel = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        ram_we = req_we[i];
        ram_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        ram_wd = req_wd[i*BITS +: BITS];
        lock_sel = req_lock[i];
      end
    end
  end
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    ptr_nxt = rr_ptr;
    if (ram_ce && state == ARB) begin
      state_nxt = lock_sel ? LOCKED : ARB;
      owner_nxt = lock_sel ? gi : owner;
      ptr_nxt = lock_sel ? rr_ptr : inc(gi);
    end else if (ram_ce && !lock_sel) begin
      state_nxt = ARB;
      ptr_nxt = inc(owner);
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ARB;
      owner <= '0;
      rr_ptr <= '0;
      rsp_valid <= '0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      rr_ptr <= ptr_nxt;
      rsp_valid <= grant;
    end
  end
endmodule

// File: tb/tb_fakeram_256x64_arb.sv
// tb_fakeram_256x64_arb: directed self-checking bench with a behavioral OR-write macro model
module tb_fakeram_256x64_arb;
  logic clk, rst;
  logic [1:0] req_valid, req_ready, req_we, req_lock, rsp_valid;
  logic [15:0] req_addr;
  logic [127:0] req_wd;
  logic [63:0] rsp_rd, ram_wd, ram_rd;
  logic ram_ce, ram_we;
  logic [7:0] ram_addr;
  logic [63:0] mem [256];
  logic x_bad;
  int checks, failures;

  fakeram_256x64_arb dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_lock(req_lock), .req_addr(req_addr), .req_wd(req_wd), .rsp_valid(rsp_valid),
    .rsp_rd(rsp_rd), .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wd(ram_wd),
    .ram_rd(ram_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
      mem[8'h10] <= 64'hA5;
      mem[8'h20] <= 64'hF0;
      mem[8'h30] <= 64'h03;
      ram_rd <= 'x;
    end else if (ram_ce) begin
      ram_rd <= mem[ram_addr];
      if (ram_we) mem[ram_addr] <= mem[ram_addr] | ram_wd;
    end else ram_rd <= 'x;
  end

  initial x_bad = 1'b0;
  always @(negedge clk) if (ram_ce !== 1'b0 && $isunknown({ram_ce, ram_we, ram_addr, ram_wd})) x_bad = 1'b1;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    @(posedge clk);
    #1 req_valid = 2'b11;
    #1;
    checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL reset_ready got=%b exp=00", req_ready); end
    checks++; if (ram_ce !== 1'b0) begin failures++; $display("FAIL reset_ce got=%b exp=0", ram_ce); end
    checks++; if (rsp_valid !== 2'b00) begin failures++; $display("FAIL reset_rsp got=%b exp=00", rsp_valid); end
    req_valid = 2'b00;
    step;
    rst = 1'b0;
  endtask

  task automatic test_single_read;
    step;
    req_valid = 2'b01; req_we = 2'b00; req_addr[7:0] = 8'h10;
    #1;
    checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL read_ready got=%b exp=01", req_ready); end
    checks++; if (ram_ce !== 1'b1 || ram_addr !== 8'h10) begin failures++; $display("FAIL read_drive got=%b/%h exp=1/10", ram_ce, ram_addr); end
    step;
    req_valid = 2'b00;
    #1;
    checks++; if (rsp_valid !== 2'b01) begin failures++; $display("FAIL read_rsp_valid got=%b exp=01", rsp_valid); end
    checks++; if (rsp_rd !== 64'hA5) begin failures++; $display("FAIL read_rsp_rd got=%h exp=a5", rsp_rd); end
  endtask

  task automatic test_or_write;
    step;
    req_valid = 2'b10; req_we = 2'b10; req_addr[15:8] = 8'h20; req_wd[127:64] = 64'h0F;
    #1;
    checks++; if (req_ready !== 2'b10) begin failures++; $display("FAIL wr_ready got=%b exp=10", req_ready); end
    step;
    req_valid = 2'b01; req_we = 2'b00; req_addr[7:0] = 8'h20;
    #1;
    checks++; if (rsp_valid !== 2'b10 || rsp_rd !== 64'hF0) begin failures++; $display("FAIL wr_rsp got=%b/%h exp=10/f0", rsp_valid, rsp_rd); end
    checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL rb_ready got=%b exp=01", req_ready); end
    step;
    req_valid = 2'b00;
    #1;
    checks++; if (rsp_valid !== 2'b01 || rsp_rd !== 64'hFF) begin failures++; $display("FAIL rb_rsp got=%b/%h exp=01/ff", rsp_valid, rsp_rd); end
  endtask

  task automatic test_round_robin;
    logic [1:0] e, prev;
    step;
    rst = 1'b1;
    step;
    rst = 1'b0;
    req_valid = 2'b11; req_we = 2'b00; req_lock = 2'b00; req_addr = 16'h2010;
    prev = 2'b00;
    for (int i = 0; i < 6; i++) begin
      e = (i % 2 == 1) ? 2'b10 : 2'b01;
      #1;
      checks++; if (req_ready !== e) begin failures++; $display("FAIL rr_grant%0d got=%b exp=%b", i, req_ready, e); end
      if (i > 0) begin
        checks++; if (rsp_valid !== prev || rsp_rd !== (prev == 2'b01 ? 64'hA5 : 64'hF0)) begin failures++; $display("FAIL rr_rsp%0d got=%b/%h exp=%b", i, rsp_valid, rsp_rd, prev); end
      end
      prev = e;
      step;
    end
    req_valid = 2'b00;
    #1;
    checks++; if (rsp_valid !== 2'b10 || rsp_rd !== 64'hF0) begin failures++; $display("FAIL rr_last got=%b/%h exp=10/f0", rsp_valid, rsp_rd); end
  endtask

  task automatic test_lock;
    step;
    req_valid = 2'b11; req_lock = 2'b01; req_we = 2'b00; req_addr = 16'h4030;
    #1;
    checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL lock_grant got=%b exp=01", req_ready); end
    step;
    req_valid = 2'b10; req_lock = 2'b00;
    #1;
    checks++; if (rsp_valid !== 2'b01 || rsp_rd !== 64'h03) begin failures++; $display("FAIL lock_rsp got=%b/%h exp=01/03", rsp_valid, rsp_rd); end
    checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL lock_block1 got=%b exp=00", req_ready); end
    step;
    #1;
    checks++; if (req_ready !== 2'b00 || ram_ce !== 1'b0) begin failures++; $display("FAIL lock_block2 got=%b/%b exp=00/0", req_ready, ram_ce); end
    step;
    req_valid = 2'b11; req_we = 2'b01; req_wd[63:0] = 64'h30;
    #1;
    checks++; if (req_ready !== 2'b01 || ram_we !== 1'b1 || ram_wd !== 64'h30) begin failures++; $display("FAIL unlock_wr got=%b/%b/%h exp=01/1/30", req_ready, ram_we, ram_wd); end
    step;
    req_we = 2'b00; req_addr[15:8] = 8'h30;
    #1;
    checks++; if (rsp_valid !== 2'b01 || rsp_rd !== 64'h03) begin failures++; $display("FAIL unlock_rsp got=%b/%h exp=01/03", rsp_valid, rsp_rd); end
    checks++; if (req_ready !== 2'b10) begin failures++; $display("FAIL after_unlock got=%b exp=10", req_ready); end
    step;
    req_valid = 2'b00;
    #1;
    checks++; if (rsp_valid !== 2'b10 || rsp_rd !== 64'h33) begin failures++; $display("FAIL lock_readback got=%b/%h exp=10/33", rsp_valid, rsp_rd); end
  endtask

  task automatic test_idle;
    step;
    req_valid = 2'b00; req_we = 2'b11; req_lock = 2'b11; req_addr = 16'hFFFF; req_wd = '1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (ram_ce !== 1'b0 || ram_we !== 1'b0 || ram_addr !== 8'h00 || ram_wd !== 64'h0) begin failures++; $display("FAIL idle%0d got=%b/%b/%h/%h exp=0/0/00/0", i, ram_ce, ram_we, ram_addr, ram_wd); end
      step;
    end
    req_we = 2'b00; req_lock = 2'b00; req_wd = '0;
  endtask

  task automatic test_reset_mid_lock;
    step;
    req_valid = 2'b11; req_lock = 2'b01; req_addr = 16'h2030;
    #1;
    checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL ml_grant got=%b exp=01", req_ready); end
    step;
    req_valid = 2'b10; req_lock = 2'b00;
    #1;
    checks++; if (rsp_valid !== 2'b01) begin failures++; $display("FAIL ml_pending got=%b exp=01", rsp_valid); end
    #2 rst = 1'b1;
    #1;
    checks++; if (rsp_valid !== 2'b00 || req_ready !== 2'b00) begin failures++; $display("FAIL ml_rst got=%b/%b exp=00/00", rsp_valid, req_ready); end
    step;
    rst = 1'b0;
    #1;
    checks++; if (rsp_valid !== 2'b00 || req_ready !== 2'b10) begin failures++; $display("FAIL ml_release got=%b/%b exp=00/10", rsp_valid, req_ready); end
    req_valid = 2'b11;
    #1;
    checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL ml_ptr got=%b exp=01", req_ready); end
    step;
    req_valid = 2'b00;
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1;
    req_valid = '0; req_we = '0; req_lock = '0; req_addr = '0; req_wd = '0;
    test_reset;
    test_single_read;
    test_or_write;
    test_round_robin;
    test_lock;
    test_idle;
    test_reset_mid_lock;
    step;
    checks++; if (x_bad !== 1'b0) begin failures++; $display("FAIL macro_x got=%b exp=0", x_bad); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
